// File: rtl/ex_alu_iterative_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_alu_iterative_if
// Description : Bundle of the operation and result signals between the
//               ID/EX stage, the execute-stage ALU and the EX/MEM register.
//               master : drives the operation (InValid, ALUControl, A, B,
//                        Shamt, Flush); samples Stall, OutValid, ALUResult
//                        and Zero.
//               slave  : the ALU side of the same signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_alu_iterative_if #(
    parameter int DATA_W = 32
);
    logic              InValid;
    logic [5:0]        ALUControl;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [4:0]        Shamt;
    logic              Flush;
    logic              Stall;
    logic              OutValid;
    logic [DATA_W-1:0] ALUResult;
    logic              Zero;

    modport master (
        output InValid, ALUControl, A, B, Shamt, Flush,
        input  Stall, OutValid, ALUResult, Zero
    );

    modport slave (
        input  InValid, ALUControl, A, B, Shamt, Flush,
        output Stall, OutValid, ALUResult, Zero
    );
endinterface
`default_nettype wire

// File: rtl/ex_alu_iterative.sv
`default_nettype none
// ============================================================================
// Module      : ex_alu_iterative
// Description : Execute-stage ALU. Single-cycle ops register their result on
//               the accept edge. mul uses an iterative shift-add multiplier
//               that retires MUL_BITS multiplier bits per cycle and holds
//               Stall high for DATA_W/MUL_BITS cycles.
//               Build option ALU_FAST_MUL_EN: mul is computed
//               combinationally like the other ops, Stall is tied low and
//               no multiplier state is built.
// Ports       : Clk    - pipeline clock, rising edge
//               Reset  - synchronous, active-high
//               bus    - ex_alu_iterative_if.slave (op in, result out)
// Revision    : 1.0 - initial release
// ============================================================================
module ex_alu_iterative #(
    parameter int DATA_W   = 32,
    parameter int MUL_BITS = 2
) (
    input  wire logic         Clk,
    input  wire logic         Reset,
    ex_alu_iterative_if.slave bus
);
    localparam logic [5:0] OP_ADD = 6'd0;
    localparam logic [5:0] OP_SUB = 6'd2;
    localparam logic [5:0] OP_MUL = 6'd3;
    localparam logic [5:0] OP_JR  = 6'd17;
    localparam logic [5:0] OP_AND = 6'd19;
    localparam logic [5:0] OP_OR  = 6'd21;
    localparam logic [5:0] OP_NOR = 6'd22;
    localparam logic [5:0] OP_XOR = 6'd23;
    localparam logic [5:0] OP_SLL = 6'd26;
    localparam logic [5:0] OP_SRL = 6'd27;
    localparam logic [5:0] OP_SLT = 6'd28;

    logic              accept;
    logic [DATA_W-1:0] single_res;
    logic              out_valid;
    logic [DATA_W-1:0] result;
    logic              zero;

    assign accept        = bus.InValid && !bus.Stall && !bus.Flush;
    assign bus.OutValid  = out_valid;
    assign bus.ALUResult = result;
    assign bus.Zero      = zero;

    // Result of every op that completes in the accept cycle.
    always_comb begin
        single_res = '0;
        case (bus.ALUControl)
            OP_ADD: single_res = bus.A + bus.B;
            OP_SUB: single_res = bus.A - bus.B;
            OP_JR:  single_res = bus.A;
            OP_AND: single_res = bus.A & bus.B;
            OP_OR:  single_res = bus.A | bus.B;
            OP_NOR: single_res = ~(bus.A | bus.B);
            OP_XOR: single_res = bus.A ^ bus.B;
            OP_SLL: single_res = bus.B << bus.Shamt;
            OP_SRL: single_res = bus.B >> bus.Shamt;
            OP_SLT: single_res = {{(DATA_W-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
`ifdef ALU_FAST_MUL_EN
            OP_MUL: single_res = bus.A * bus.B;
`endif
            default: single_res = '0;
        endcase
    end

`ifdef ALU_FAST_MUL_EN

    assign bus.Stall = 1'b0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
        end else if (bus.Flush) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                result <= single_res;
                zero   <= (single_res == '0);
            end
        end
    end

`else

    localparam int MUL_STEPS = DATA_W / MUL_BITS;
    localparam int CNT_W     = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_STEPS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mcand;   // pre-shifted by cnt*MUL_BITS each step
    logic [DATA_W-1:0] mplier;  // low MUL_BITS hold the current digit
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_next;
    logic              mul_done;

    assign acc_next  = acc + mcand * {{(DATA_W-MUL_BITS){1'b0}}, mplier[MUL_BITS-1:0]};
    assign mul_done  = (state == S_MUL) && (cnt == CNT_LAST) && !bus.Flush;
    assign bus.Stall = (state == S_MUL);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept && bus.ALUControl == OP_MUL) state_next = S_MUL;
            S_MUL:  if (bus.Flush || cnt == CNT_LAST)       state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
        end else if (bus.Flush) begin
            // Abort any multiply in flight; ALUResult/Zero keep their value.
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            out_valid <= 1'b0;
            if (state == S_MUL) begin
                acc    <= acc_next;
                mcand  <= mcand << MUL_BITS;
                mplier <= mplier >> MUL_BITS;
                cnt    <= cnt + 1'b1;
                if (mul_done) begin
                    result    <= acc_next;
                    zero      <= (acc_next == '0);
                    out_valid <= 1'b1;
                end
            end else if (accept) begin
                if (bus.ALUControl == OP_MUL) begin
                    mcand  <= bus.A;
                    mplier <= bus.B;
                    acc    <= '0;
                    cnt    <= '0;
                end else begin
                    result    <= single_res;
                    zero      <= (single_res == '0);
                    out_valid <= 1'b1;
                end
            end
        end
    end

`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_alu_iterative.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_alu_iterative
// Description : Directed self-checking bench for ex_alu_iterative. Each task
//               drives one scenario and compares against hand-computed
//               values. Build with ALU_FAST_MUL_EN to exercise the
//               single-cycle multiplier variant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_alu_iterative;
    logic Clk;
    logic Reset;
    int   n_cmp;
    int   n_err;

    ex_alu_iterative_if #(.DATA_W(32)) bus ();

    ex_alu_iterative #(
        .DATA_W   (32),
        .MUL_BITS (2)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
        bus.InValid    = 1'b1;
        bus.ALUControl = op;
        bus.A          = a;
        bus.B          = b;
        bus.Shamt      = sh;
    endtask

    task automatic idle();
        bus.InValid    = 1'b0;
        bus.ALUControl = 6'd0;
        bus.A          = '0;
        bus.B          = '0;
        bus.Shamt      = '0;
    endtask

    task automatic test_reset();
        idle();
        bus.Flush = 1'b0;
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        n_cmp++; if (bus.OutValid !== 1'b0) begin n_err++; $display("FAIL reset_outvalid got %b exp 0", bus.OutValid); end
        n_cmp++; if (bus.ALUResult !== 32'h0) begin n_err++; $display("FAIL reset_result got %h exp 00000000", bus.ALUResult); end
        n_cmp++; if (bus.Zero !== 1'b1) begin n_err++; $display("FAIL reset_zero got %b exp 1", bus.Zero); end
        n_cmp++; if (bus.Stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b exp 0", bus.Stall); end
    endtask

    task automatic test_add_sub();
        drive(6'd0, 32'h7FFF_FFFF, 32'h1, 5'd0);
        step();
        n_cmp++; if (bus.OutValid !== 1'b1 || bus.ALUResult !== 32'h8000_0000 || bus.Zero !== 1'b0)
            begin n_err++; $display("FAIL add_wrap got v=%b r=%h z=%b exp v=1 r=80000000 z=0", bus.OutValid, bus.ALUResult, bus.Zero); end
        drive(6'd2, 32'd5, 32'd5, 5'd0);
        step();
        n_cmp++; if (bus.OutValid !== 1'b1 || bus.ALUResult !== 32'h0 || bus.Zero !== 1'b1)
            begin n_err++; $display("FAIL sub_zero got v=%b r=%h z=%b exp v=1 r=00000000 z=1", bus.OutValid, bus.ALUResult, bus.Zero); end
        idle();
        step();
        n_cmp++; if (bus.OutValid !== 1'b0 || bus.ALUResult !== 32'h0 || bus.Zero !== 1'b1)
            begin n_err++; $display("FAIL idle_hold got v=%b r=%h z=%b exp v=0 r=00000000 z=1", bus.OutValid, bus.ALUResult, bus.Zero); end
    endtask

    task automatic test_ops();
        logic [5:0]  ops [11];
        logic [31:0] as  [11];
        logic [31:0] bs  [11];
        logic [4:0]  shs [11];
        logic [31:0] exp_r [11];
        ops[0]  = 6'd28; as[0]  = 32'hFFFF_FFFF; bs[0]  = 32'h1;         shs[0]  = 5'd0;  exp_r[0]  = 32'h1;
        ops[1]  = 6'd26; as[1]  = 32'h0;         bs[1]  = 32'h1;         shs[1]  = 5'd31; exp_r[1]  = 32'h8000_0000;
        ops[2]  = 6'd27; as[2]  = 32'h0;         bs[2]  = 32'h8000_0000; shs[2]  = 5'd31; exp_r[2]  = 32'h1;
        ops[3]  = 6'd63; as[3]  = 32'h1234_5678; bs[3]  = 32'h9ABC_DEF0; shs[3]  = 5'd3;  exp_r[3]  = 32'h0;
        ops[4]  = 6'd19; as[4]  = 32'hF0F0_1234; bs[4]  = 32'h0FF0_FFFF; shs[4]  = 5'd0;  exp_r[4]  = 32'h00F0_1234;
        ops[5]  = 6'd21; as[5]  = 32'hF0F0_1234; bs[5]  = 32'h0FF0_FFFF; shs[5]  = 5'd0;  exp_r[5]  = 32'hFFF0_FFFF;
        ops[6]  = 6'd22; as[6]  = 32'hF0F0_1234; bs[6]  = 32'h0FF0_FFFF; shs[6]  = 5'd0;  exp_r[6]  = 32'h000F_0000;
        ops[7]  = 6'd23; as[7]  = 32'hF0F0_1234; bs[7]  = 32'h0FF0_FFFF; shs[7]  = 5'd0;  exp_r[7]  = 32'hFF00_EDCB;
        ops[8]  = 6'd17; as[8]  = 32'hDEAD_BEEF; bs[8]  = 32'h1;         shs[8]  = 5'd0;  exp_r[8]  = 32'hDEAD_BEEF;
        ops[9]  = 6'd28; as[9]  = 32'h1;         bs[9]  = 32'hFFFF_FFFF; shs[9]  = 5'd0;  exp_r[9]  = 32'h0;
        ops[10] = 6'd2;  as[10] = 32'h0;         bs[10] = 32'h1;         shs[10] = 5'd0;  exp_r[10] = 32'hFFFF_FFFF;
        // Presented back to back: one result per cycle.
        for (int i = 0; i < 11; i++) begin
            drive(ops[i], as[i], bs[i], shs[i]);
            step();
            n_cmp++; if (bus.OutValid !== 1'b1 || bus.ALUResult !== exp_r[i] || bus.Zero !== (exp_r[i] == 32'h0))
                begin n_err++; $display("FAIL op%0d_vec%0d got v=%b r=%h z=%b exp v=1 r=%h z=%b", ops[i], i, bus.OutValid, bus.ALUResult, bus.Zero, exp_r[i], (exp_r[i] == 32'h0)); end
        end
        idle();
        step();
    endtask

    task automatic test_flush_idle();
        drive(6'd0, 32'd10, 32'd20, 5'd0);
        step();
        n_cmp++; if (bus.OutValid !== 1'b1 || bus.ALUResult !== 32'd30)
            begin n_err++; $display("FAIL add_30 got v=%b r=%h exp v=1 r=0000001e", bus.OutValid, bus.ALUResult); end
        drive(6'd0, 32'd1, 32'd1, 5'd0);
        bus.Flush = 1'b1;
        step();
        bus.Flush = 1'b0;
        idle();
        n_cmp++; if (bus.OutValid !== 1'b0 || bus.ALUResult !== 32'd30)
            begin n_err++; $display("FAIL flush_idle got v=%b r=%h exp v=0 r=0000001e", bus.OutValid, bus.ALUResult); end
    endtask

    task automatic test_mul_back_to_back();
`ifdef ALU_FAST_MUL_EN
        drive(6'd3, 32'hFFFF_FFFF, 32'd7, 5'd0);
        step();
        n_cmp++; if (bus.OutValid !== 1'b1 || bus.ALUResult !== 32'hFFFF_FFF9 || bus.Stall !== 1'b0)
            begin n_err++; $display("FAIL fast_mul_neg got v=%b r=%h s=%b exp v=1 r=fffffff9 s=0", bus.OutValid, bus.ALUResult, bus.Stall); end
        drive(6'd0, 32'd2, 32'd3, 5'd0);
        step();
        n_cmp++; if (bus.OutValid !== 1'b1 || bus.ALUResult !== 32'd5)
            begin n_err++; $display("FAIL add_after_mul got v=%b r=%h exp v=1 r=00000005", bus.OutValid, bus.ALUResult); end
`else
        int stall_cycles;
        bit early_valid;
        drive(6'd3, 32'hFFFF_FFFF, 32'd7, 5'd0);
        step();
        n_cmp++; if (bus.OutValid !== 1'b0 || bus.Stall !== 1'b1)
            begin n_err++; $display("FAIL mul_accept got v=%b s=%b exp v=0 s=1", bus.OutValid, bus.Stall); end
        // Queued add held on the inputs throughout the stall.
        drive(6'd0, 32'd2, 32'd3, 5'd0);
        stall_cycles = 0;
        early_valid = 1'b0;
        while (bus.Stall === 1'b1 && stall_cycles < 40) begin
            if (bus.OutValid !== 1'b0) early_valid = 1'b1;
            stall_cycles++;
            step();
        end
        n_cmp++; if (stall_cycles != 16)
            begin n_err++; $display("FAIL mul_stall_len got %0d exp 16", stall_cycles); end
        n_cmp++; if (early_valid)
            begin n_err++; $display("FAIL mul_early_valid got 1 exp 0"); end
        n_cmp++; if (bus.OutValid !== 1'b1 || bus.ALUResult !== 32'hFFFF_FFF9 || bus.Zero !== 1'b0)
            begin n_err++; $display("FAIL mul_neg got v=%b r=%h z=%b exp v=1 r=fffffff9 z=0", bus.OutValid, bus.ALUResult, bus.Zero); end
        step();
        n_cmp++; if (bus.OutValid !== 1'b1 || bus.ALUResult !== 32'd5)
            begin n_err++; $display("FAIL queued_add got v=%b r=%h exp v=1 r=00000005", bus.OutValid, bus.ALUResult); end
`endif
        idle();
        step();
    endtask

    task automatic test_mul_flush();
`ifdef ALU_FAST_MUL_EN
        drive(6'd3, 32'd123, 32'd456, 5'd0);
        step();
        idle();
        n_cmp++; if (bus.OutValid !== 1'b1 || bus.ALUResult !== 32'd56088 || bus.Stall !== 1'b0)
            begin n_err++; $display("FAIL fast_mul got v=%b r=%h s=%b exp v=1 r=0000db18 s=0", bus.OutValid, bus.ALUResult, bus.Stall); end
`else
        bit saw_valid;
        drive(6'd3, 32'd123, 32'd456, 5'd0);
        step();
        idle();
        // Now in stall cycle 1; advance to stall cycle 5.
        for (int i = 1; i < 5; i++) step();
        n_cmp++; if (bus.Stall !== 1'b1)
            begin n_err++; $display("FAIL mul_stall_c5 got %b exp 1", bus.Stall); end
        bus.Flush = 1'b1;
        step();
        bus.Flush = 1'b0;
        n_cmp++; if (bus.Stall !== 1'b0 || bus.OutValid !== 1'b0 || bus.ALUResult !== 32'd5)
            begin n_err++; $display("FAIL mul_flush got s=%b v=%b r=%h exp s=0 v=0 r=00000005", bus.Stall, bus.OutValid, bus.ALUResult); end
        saw_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.OutValid !== 1'b0 || bus.Stall !== 1'b0) saw_valid = 1'b1;
            step();
        end
        n_cmp++; if (saw_valid || bus.ALUResult !== 32'd5)
            begin n_err++; $display("FAIL mul_flush_quiet got activity=%b r=%h exp activity=0 r=00000005", saw_valid, bus.ALUResult); end
`endif
    endtask

    task automatic test_reset_mid_mul();
        drive(6'd3, 32'd3, 32'd5, 5'd0);
        step();
        idle();
        step();
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        n_cmp++; if (bus.OutValid !== 1'b0 || bus.ALUResult !== 32'h0 || bus.Zero !== 1'b1 || bus.Stall !== 1'b0)
            begin n_err++; $display("FAIL reset_mid got v=%b r=%h z=%b s=%b exp v=0 r=00000000 z=1 s=0", bus.OutValid, bus.ALUResult, bus.Zero, bus.Stall); end
        drive(6'd0, 32'd1, 32'd2, 5'd0);
        step();
        idle();
        n_cmp++; if (bus.OutValid !== 1'b1 || bus.ALUResult !== 32'd3)
            begin n_err++; $display("FAIL add_after_reset got v=%b r=%h exp v=1 r=00000003", bus.OutValid, bus.ALUResult); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        Reset = 1'b1;
        bus.Flush = 1'b0;
        idle();
        test_reset();
        test_add_sub();
        test_ops();
        test_flush_idle();
        test_mul_back_to_back();
        test_mul_flush();
        test_reset_mid_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
